// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a built-in bring-up banner.
//
// One byte per accepted request is sent as start bit, eight data bits
// LSB first and one stop bit, each bit held CLKS_PER_BIT clock cycles.
// With test_mode_i high the block sends the fixed banner
// "Hello! RISCV!\r\n" once, without anything driving data_i or valid_i.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, not busy; accepts a banner byte or a valid_i request
// START | start bit (line low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (line high) for one bit period, then back to IDLE

module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 1_152_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       test_mode_i,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BANNER_LEN = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [3:0]       test_ptr, ptr_nxt;
    logic             baud_done;

    // Banner ROM, indexed by test_ptr.
    function automatic logic [7:0] banner_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    banner_byte = 8'h48;
            4'd1:    banner_byte = 8'h65;
            4'd2:    banner_byte = 8'h6C;
            4'd3:    banner_byte = 8'h6C;
            4'd4:    banner_byte = 8'h6F;
            4'd5:    banner_byte = 8'h21;
            4'd6:    banner_byte = 8'h20;
            4'd7:    banner_byte = 8'h52;
            4'd8:    banner_byte = 8'h49;
            4'd9:    banner_byte = 8'h53;
            4'd10:   banner_byte = 8'h43;
            4'd11:   banner_byte = 8'h56;
            4'd12:   banner_byte = 8'h21;
            4'd13:   banner_byte = 8'h0D;
            4'd14:   banner_byte = 8'h0A;
            default: banner_byte = 8'h00;
        endcase
    endfunction

    assign baud_done = (baud_cnt == BAUD_LAST);

    // State, counters, shift register and banner pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            test_ptr  <= '0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            test_ptr  <= ptr_nxt;
        end
    end

    // Next-state logic plus line/busy outputs decoded from the current state.
    // Outputs come straight from state so an async reset drops the line to
    // idle at once, and the start bit appears the cycle after acceptance.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        ptr_nxt   = test_ptr;
        tx_o      = 1'b1;
        busy_o    = 1'b1;

        case (state)
            IDLE: begin
                busy_o   = 1'b0;
                baud_nxt = '0;
                bit_nxt  = '0;
                // Test mode wins over valid_i, even once the banner is done.
                if (test_mode_i) begin
                    if (test_ptr != BANNER_LEN) begin
                        shift_nxt = banner_byte(test_ptr);
                        ptr_nxt   = test_ptr + 4'd1;
                        state_nxt = START;
                    end
                end else if (valid_i) begin
                    shift_nxt = data_i;
                    state_nxt = START;
                end
            end

            START: begin
                tx_o = 1'b0;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                tx_o = shift_reg[0];
                if (baud_done) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                tx_o = 1'b1;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Leaving test mode rewinds the banner; a frame in flight still finishes.
        if (!test_mode_i) begin
            ptr_nxt = '0;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at default parameters (86 clocks per bit).
module tb_uart_tx;

    localparam int CPB   = 86;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       test_mode = 1'b0;
    logic       busy;
    logic       tx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data),
        .valid_i     (valid),
        .test_mode_i (test_mode),
        .busy_o      (busy),
        .tx_o        (tx)
    );

    typedef struct {
        logic [7:0] byte_in;
        logic [9:0] exp_line;  // first transmitted bit in the MSB
        logic       b2b;       // issue in the first idle cycle after the previous frame
        int         spur_t;    // frame cycle of an extra request, -1 for none
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic request(input logic [7:0] d);
        data  = d;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Starts at the negedge after acceptance (frame cycle 0), returns at cycle 860.
    task automatic capture(input int spur_t, output logic [9:0] first, output logic [9:0] mid,
                           output logic [9:0] last, output logic busy_all);
        first = '0;
        mid = '0;
        last = '0;
        busy_all = 1'b1;
        for (int t = 0; t < FRAME; t++) begin
            if (t % CPB == 0)        first = {first[8:0], tx};
            if (t % CPB == CPB / 2)  mid   = {mid[8:0], tx};
            if (t % CPB == CPB - 1)  last  = {last[8:0], tx};
            if (busy !== 1'b1) busy_all = 1'b0;
            if (t == 100) data = ~data;
            if (t == spur_t) begin
                data  = 8'hFF;
                valid = 1'b1;
            end
            if (t == spur_t + 2) valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic frame_checks(input string name, input logic [9:0] exp, input logic [9:0] first,
                                input logic [9:0] mid, input logic [9:0] last, input logic busy_all);
        check({name, "_bit_start"}, first, exp);
        check({name, "_bit_mid"}, mid, exp);
        check({name, "_bit_end"}, last, exp);
        check({name, "_busy_span"}, busy_all, 1'b1);
        check({name, "_busy_low_after"}, busy, 1'b0);
    endtask

    initial begin
        logic [9:0] f, m, l;
        logic       ba;
        logic       stayed_idle;
        logic [9:0] exp_b;
        logic [7:0] ch;
        string      banner = "Hello! RISCV!\r\n";

        vecs[0] = '{8'h41, 10'b0100000101, 1'b0, -1};
        vecs[1] = '{8'h42, 10'b0010000101, 1'b0, 200};
        vecs[2] = '{8'h00, 10'b0000000001, 1'b0, -1};
        vecs[3] = '{8'hFF, 10'b0111111111, 1'b1, -1};
        vecs[4] = '{8'hA5, 10'b0101001011, 1'b1, -1};
        vecs[5] = '{8'h3C, 10'b0001111001, 1'b0, -1};

        // Reset held for 100 ns.
        #99;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_test_ptr", dut.test_ptr, 4'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].b2b) begin
                stayed_idle = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    if (busy !== 1'b0 || tx !== 1'b1) stayed_idle = 1'b0;
                    @(negedge clk);
                end
                check($sformatf("idle_before_v%0d", i), stayed_idle, 1'b1);
            end
            request(vecs[i].byte_in);
            capture(vecs[i].spur_t, f, m, l, ba);
            frame_checks($sformatf("v%0d", i), vecs[i].exp_line, f, m, l, ba);
        end

        // Reset in the middle of a data bit, then a clean frame.
        @(negedge clk);
        request(8'h41);
        repeat (300) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_tx", tx, 1'b1);
        check("midreset_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_busy", busy, 1'b0);
        request(8'h5A);
        capture(-1, f, m, l, ba);
        frame_checks("post_reset", 10'b0010110101, f, m, l, ba);

        // Banner in test mode.
        @(negedge clk);
        test_mode = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            capture(-1, f, m, l, ba);
            ch = banner[k];
            exp_b = '0;
            exp_b[9] = 1'b0;
            for (int b = 0; b < 8; b++) exp_b[8 - b] = ch[b];
            exp_b[0] = 1'b1;
            check($sformatf("banner_%0d", k), m, exp_b);
            check($sformatf("banner_busy_%0d", k), ba, 1'b1);
            if (k < 14) @(negedge clk);
        end
        check("banner_ptr_sat", dut.test_ptr, 4'd15);

        // Banner done: valid_i ignored while test mode is held.
        data = 8'h55;
        valid = 1'b1;
        stayed_idle = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (busy !== 1'b0 || tx !== 1'b1) stayed_idle = 1'b0;
            @(negedge clk);
        end
        valid = 1'b0;
        check("banner_then_quiet", stayed_idle, 1'b1);

        test_mode = 1'b0;
        @(negedge clk);
        check("test_ptr_cleared", dut.test_ptr, 4'd0);

        // Re-entering test mode restarts the banner at 'H'.
        test_mode = 1'b1;
        @(negedge clk);
        capture(-1, f, m, l, ba);
        check("banner_restart", m, 10'b0000100101);
        test_mode = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
